sample_packer: RTL and testbench

- Parametrised front end between the ADC sample inputs and the packet streamer.
- Per sample, for each of NCH complex channels:
  - decodes bit-reversed Gray-coded I/Q bytes to two's complement;
  - applies a CPU-set DC offset with saturation;
  - quantises to QBITS bits per component.
- Packs the results MSB-first into 16-bit words with a one-cycle valid strobe.
- Keeps a saturation-event counter for the housekeeping CPU.
- Generalises the fixed 2-channel, 2-bit shift-and-toggle packing to configurable channel count and depth, and adds enable framing.

---
 rtl/sample_packer_if.sv | 18 +
 rtl/sample_packer.sv | 158 +++++++++++++++
 tb/tb_sample_packer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sample_packer_if.sv
// sample_packer_if -- sample-in / packed-word-out bus of sample_packer.
//   raw_data  : 16*NCH bits. Channel c uses [16c+15:16c+8] for the I byte and
//               [16c+7:16c] for the Q byte.
//   raw_en    : qualifies raw_data in this cycle.
//   out_data  : packed 16-bit word.
//   out_valid : one-cycle strobe; out_data is valid while it is high.
// The master modport is the ADC/bench side. The slave modport is the packer side.
interface sample_packer_if #(
  parameter int NCH = 2
);
  logic [16*NCH-1:0] raw_data;
  logic              raw_en;
  logic [15:0]       out_data;
  logic              out_valid;

  modport master (output raw_data, output raw_en, input out_data, input out_valid);
  modport slave  (input raw_data, input raw_en, output out_data, output out_valid);
endinterface

// File: rtl/sample_packer.sv
// sample_packer -- ADC front end. It has three pipeline stages and a word packer.
//   Stage 1 decodes the bit-reversed Gray-coded bytes to two's complement.
//   Stage 2 adds the DC offset and saturates to 8 bits.
//   Stage 3 quantises each component to QBITS bits.
//   The packer shifts the results MSB-first into 16-bit words.
// Ports:
//   clk       : sample clock.
//   reset_n   : asynchronous active-low reset.
//   bus       : raw_data/raw_en in, out_data/out_valid out (sample_packer_if.slave).
//   dc        : signed 8-bit offset per component, laid out like raw_data.
//   thresh    : magnitude threshold, used when QBITS = 2.
//   sat_count : count of stage-2 cycles that had any saturated component.
//               It stops at 0xFFFF.
//   sat_clear : synchronous clear of sat_count. It wins over an increment.
module sample_packer #(
  parameter int NCH   = 2,
  parameter int QBITS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  sample_packer_if.slave    bus,
  input  logic [16*NCH-1:0] dc,
  input  logic [7:0]        thresh,
  output logic [15:0]       sat_count,
  input  logic              sat_clear
);

  localparam int NC = 2 * NCH;
  localparam int SB = NC * QBITS;
  localparam int N  = 16 / SB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Component j is ch(j/2), I when j is even and Q when j is odd.
  // Its byte lane is j^1 because the I byte sits above the Q byte.
  function automatic logic [7:0] gray_decode(input logic [7:0] x);
    logic [7:0] xr;
    logic [7:0] z;
    for (int unsigned i = 0; i < 8; i++) xr[i] = x[7-i];
    z[7] = xr[7];
    for (int unsigned i = 1; i < 8; i++) z[7-i] = xr[7-i] ^ z[8-i];
    return {~z[7], z[6:0]};
  endfunction

  logic [7:0]    s1_v [NC];
  logic          s1_valid;
  logic [7:0]    s2_s [NC];
  logic          s2_sat;
  logic          s2_valid;
  logic [SB-1:0] s3_sample;
  logic          s3_valid;

  logic [7:0]    v_next [NC];
  logic [7:0]    s_next [NC];
  logic          sat_next;
  logic [SB-1:0] sample_next;

  logic [15:0]   shift;
  logic [15:0]   shift_next;
  logic [CW-1:0] cnt;

  always_comb begin
    for (int unsigned j = 0; j < NC; j++) v_next[j] = gray_decode(bus.raw_data[8*(j^1) +: 8]);
  end

  // A 9-bit sum overflows 8 bits when bit 8 and bit 7 differ.
  // Bit 8 then gives the clamp direction.
  always_comb begin
    logic [8:0] sum;
    logic [7:0] off;
    sat_next = 1'b0;
    sum      = '0;
    off      = '0;
    for (int unsigned j = 0; j < NC; j++) begin
      off = dc[8*(j^1) +: 8];
      sum = {s1_v[j][7], s1_v[j]} + {off[7], off};
      if (sum[8] != sum[7]) begin
        s_next[j] = sum[8] ? 8'h80 : 8'h7F;
        sat_next  = 1'b1;
      end else begin
        s_next[j] = sum[7:0];
      end
    end
  end

  always_comb begin
    logic [7:0] mag;
    logic [3:0] q4;
    sample_next = '0;
    mag         = '0;
    q4          = '0;
    for (int unsigned j = 0; j < NC; j++) begin
      // The 8-bit negation of 0x80 gives 0x80, so |-128| reads as 128 unsigned.
      mag = s2_s[j][7] ? (~s2_s[j] + 8'd1) : s2_s[j];
      if (QBITS == 1)      q4 = {3'b000, s2_s[j][7]};
      else if (QBITS == 2) q4 = {2'b00, s2_s[j][7], (mag >= thresh)};
      else                 q4 = s2_s[j][7:4];
      sample_next[SB-1-QBITS*j -: QBITS] = q4[QBITS-1:0];
    end
  end

  // Keep the low 16 bits of {shift, sample}. This also covers SB = 16.
  assign shift_next = 16'({shift, s3_sample});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < NC; j++) begin
        s1_v[j] <= '0;
        s2_s[j] <= '0;
      end
      s1_valid  <= 1'b0;
      s2_sat    <= 1'b0;
      s2_valid  <= 1'b0;
      s3_sample <= '0;
      s3_valid  <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < NC; j++) begin
        s1_v[j] <= v_next[j];
        s2_s[j] <= s_next[j];
      end
      s1_valid  <= bus.raw_en;
      s2_sat    <= sat_next;
      s2_valid  <= s1_valid;
      s3_sample <= sample_next;
      s3_valid  <= s2_valid;
    end
  end

  // A stage-3 gap restarts word assembly, so partial words are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift         <= '0;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (s3_valid) begin
        shift <= shift_next;
        if (cnt == CW'(N - 1)) begin
          cnt           <= '0;
          bus.out_data  <= shift_next;
          bus.out_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   sat_count <= '0;
    else if (sat_clear)                             sat_count <= '0;
    else if (s2_valid && s2_sat && sat_count != '1) sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer -- directed bench for sample_packer.
// It uses two instances: NCH=2/QBITS=2 (u_dut22) and NCH=4/QBITS=1 (u_dut41).
// Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
module tb_sample_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] dc22;
  logic [63:0] dc41;
  logic [7:0]  th22, th41;
  logic        clr22, clr41;
  logic [15:0] sat22, sat41;

  sample_packer_if #(.NCH(2)) bus22 ();
  sample_packer_if #(.NCH(4)) bus41 ();

  sample_packer #(.NCH(2), .QBITS(2)) u_dut22 (
    .clk(clk), .reset_n(reset_n), .bus(bus22), .dc(dc22),
    .thresh(th22), .sat_count(sat22), .sat_clear(clr22)
  );

  sample_packer #(.NCH(4), .QBITS(1)) u_dut41 (
    .clk(clk), .reset_n(reset_n), .bus(bus41), .dc(dc41),
    .thresh(th41), .sat_count(sat41), .sat_clear(clr41)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives raw_en from pat[0..len-1] on one instance, then 8 idle cycles.
  // It then checks the word count, the edge index of the first out_valid,
  // and the last word.
  task automatic burst(input int which, input logic [15:0] pat, input int len,
                       input int exp_pulses, input int exp_first,
                       input logic [15:0] exp_data, input string tag);
    int          pulses;
    int          first;
    logic [15:0] last;
    logic        en;
    logic        ov;
    pulses = 0;
    first  = -1;
    last   = '0;
    for (int e = 0; e < len + 8; e++) begin
      en = (e < len) ? pat[e] : 1'b0;
      if (which == 0) bus22.raw_en = en;
      else            bus41.raw_en = en;
      tick();
      ov = (which == 0) ? bus22.out_valid : bus41.out_valid;
      if (ov) begin
        pulses++;
        if (first < 0) first = e;
        last = (which == 0) ? bus22.out_data : bus41.out_data;
      end
    end
    check_eq({tag, "_pulses"}, pulses, exp_pulses);
    check_eq({tag, "_first"}, first, exp_first);
    check_eq({tag, "_data"}, {16'h0, last}, {16'h0, exp_data});
  endtask

  initial begin
    reset_n        = 1'b0;
    bus22.raw_data = '0;
    bus22.raw_en   = 1'b0;
    bus41.raw_data = '0;
    bus41.raw_en   = 1'b0;
    dc22  = '0;
    dc41  = '0;
    th22  = 8'd4;
    th41  = 8'd0;
    clr22 = 1'b0;
    clr41 = 1'b0;
    tick();
    tick();
    check_eq("rst_data22",  bus22.out_data,  0);
    check_eq("rst_valid22", bus22.out_valid, 0);
    check_eq("rst_sat22",   sat22,           0);
    check_eq("rst_data41",  bus41.out_data,  0);
    check_eq("rst_valid41", bus41.out_valid, 0);
    check_eq("rst_sat41",   sat41,           0);
    reset_n = 1'b1;

    // +5 everywhere with thresh 4 gives component 01. The first word appears
    // after edge 4, and one word follows every 2 cycles after that.
    bus22.raw_data = 32'hE3E3_E3E3;
    burst(0, 16'hFFFF, 16, 8, 4, 16'h5555, "plus5");
    check_eq("plus5_sat", sat22, 0);

    // A zero value is below thresh 1 and reaches thresh 0.
    bus22.raw_data = 32'h0303_0303;
    th22 = 8'd1;
    burst(0, 16'h000F, 4, 2, 4, 16'h0000, "zero_th1");
    th22 = 8'd0;
    burst(0, 16'h000F, 4, 2, 4, 16'h5555, "zero_th0");

    // 0x00 decodes to -128 on ch0 I. |-128| = 128 reaches thresh 128.
    bus22.raw_data = 32'hE3E3_00E3;
    th22 = 8'd4;
    burst(0, 16'h000F, 4, 2, 4, 16'hD5D5, "neg128_th4");
    th22 = 8'd128;
    burst(0, 16'h000F, 4, 2, 4, 16'hC0C0, "neg128_th128");

    // raw_en = 1,0,1,1 drops the lone first sample. One word appears
    // 3 cycles after the last valid sample.
    bus22.raw_data = 32'hE3E3_E3E3;
    th22 = 8'd4;
    burst(0, 16'h000D, 4, 1, 6, 16'h5555, "framing");

    // +5 plus 0x7F saturates on ch0 I. One count per valid sample.
    dc22 = 32'h0000_7F00;
    clr22 = 1'b1;
    tick();
    clr22 = 1'b0;
    burst(0, 16'h000F, 4, 2, 4, 16'h5555, "dcsat");
    check_eq("dcsat_count", sat22, 4);

    // A clear that lands on a saturating stage-2 cycle wins.
    clr22 = 1'b1;
    tick();
    clr22 = 1'b0;
    bus22.raw_en = 1'b1;
    tick();
    tick();
    tick();
    check_eq("sat_first_inc", sat22, 1);
    clr22 = 1'b1;
    tick();
    check_eq("sat_clear_wins", sat22, 0);
    clr22 = 1'b0;
    tick();
    check_eq("sat_after_clear", sat22, 1);
    bus22.raw_en = 1'b0;
    repeat (5) tick();

    // NCH=4, QBITS=1: ch0 I = -128 and the rest are +5. Each sample byte is 0x80.
    bus41.raw_data = 64'hE3E3_E3E3_E3E3_00E3;
    burst(1, 16'h000F, 4, 2, 4, 16'h8080, "nch4");
    check_eq("nch4_sat0", sat41, 0);
    dc41 = 64'h0000_0000_0000_FF00;
    burst(1, 16'h000F, 4, 2, 4, 16'h8080, "nch4_dcm1");
    check_eq("nch4_sat", sat41, 4);

    // Reset mid-stream clears the outputs at once. The first word after
    // release needs N+3 valid cycles.
    bus22.raw_en = 1'b1;
    repeat (5) tick();
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", bus22.out_valid, 0);
    check_eq("mid_rst_data",  bus22.out_data,  0);
    check_eq("mid_rst_sat",   sat22,           0);
    tick();
    reset_n = 1'b1;
    burst(0, 16'h00FF, 8, 4, 4, 16'h5555, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
